// File: rtl/lhca_stepper.sv
// Linear hybrid cellular automaton (rule 90/150 per cell, null boundaries) with
// a free-run prescaler, single-step mode, seed load, lock-up recovery and period measurement.
module lhca_stepper #(
    parameter int                 WIDTH         = 8,
    parameter logic [WIDTH-1:0]   RULE          = WIDTH'(8'h06),
    parameter logic [WIDTH-1:0]   SEED          = WIDTH'(8'h01),
    parameter int                 PRESCALE_BITS = 22,
    parameter int                 CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_o,
    output logic             o_tick,
    output logic             o_stuck,
    output logic [CNT_W-1:0] o_cycle_len,
    output logic             o_cycle_valid
);

    logic [WIDTH-1:0]         r_state;
    logic [WIDTH-1:0]         r_ref;
    logic [PRESCALE_BITS-1:0] r_presc;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         r_cycle_len;
    logic                     r_cycle_valid;
    logic                     r_tick;
    logic                     r_stuck;

    logic [WIDTH-1:0]         w_next;
    logic [CNT_W-1:0]         w_count_inc;
    logic                     w_carry;
    logic                     w_adv;

    // Shifts pull in zeros at both ends, which gives the null boundary for free.
    assign w_next      = (r_state << 1) ^ (r_state >> 1) ^ (RULE & r_state);
    assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);
    assign w_carry     = i_en & (&r_presc);
    assign w_adv       = !i_load & i_en & (i_mode ? i_step : w_carry);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state       <= SEED;
            r_ref         <= SEED;
            r_presc       <= '0;
            r_count       <= '0;
            r_cycle_len   <= '0;
            r_cycle_valid <= 1'b0;
            r_tick        <= 1'b0;
            r_stuck       <= 1'b0;
        end else if (i_load) begin
            r_state       <= i_load_value;
            r_ref         <= i_load_value;
            r_presc       <= '0;
            r_count       <= '0;
            r_cycle_valid <= 1'b0;
            r_tick        <= 1'b0;
            r_stuck       <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_stuck <= 1'b0;
            if (i_en) begin
                r_presc <= r_presc + PRESCALE_BITS'(1);
            end
            if (w_adv) begin
                // All-zero is a fixed point of the CA, so recover by reseeding.
                if (r_state == '0) begin
                    r_state <= SEED;
                    r_ref   <= SEED;
                    r_count <= '0;
                    r_stuck <= 1'b1;
                end else begin
                    r_state <= w_next;
                    r_tick  <= 1'b1;
                    if (w_next == r_ref) begin
                        r_cycle_len   <= w_count_inc;
                        r_cycle_valid <= 1'b1;
                        r_count       <= '0;
                    end else begin
                        r_count <= w_count_inc;
                    end
                end
            end
        end
    end

    assign o_o           = r_state;
    assign o_tick        = r_tick;
    assign o_stuck       = r_stuck;
    assign o_cycle_len   = r_cycle_len;
    assign o_cycle_valid = r_cycle_valid;

endmodule

// File: tb/tb_lhca_stepper.sv
// Directed bench for lhca_stepper: three instances (8-bit default rules, 2-bit
// rule 90 pair, 2-bit rule 150 pair) share clock and controls.
module tb_lhca_stepper;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       step = 1'b0;
    logic       load = 1'b0;
    logic [7:0] lv8 = 8'h00;
    logic [1:0] lv2 = 2'b00;

    logic [7:0]  a_o;
    logic        a_tick, a_stuck, a_valid;
    logic [15:0] a_len;
    logic [1:0]  b_o;
    logic        b_tick, b_stuck, b_valid;
    logic [15:0] b_len;
    logic [1:0]  c_o;
    logic        c_tick, c_stuck, c_valid;
    logic [15:0] c_len;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    lhca_stepper #(.WIDTH(8), .RULE(8'h06), .SEED(8'h01), .PRESCALE_BITS(3), .CNT_W(16)) u_a (
        .i_clk(clk), .i_resetn(resetn), .i_en(en), .i_mode(mode), .i_step(step),
        .i_load(load), .i_load_value(lv8), .o_o(a_o), .o_tick(a_tick),
        .o_stuck(a_stuck), .o_cycle_len(a_len), .o_cycle_valid(a_valid));

    lhca_stepper #(.WIDTH(2), .RULE(2'b00), .SEED(2'b01), .PRESCALE_BITS(3), .CNT_W(16)) u_b (
        .i_clk(clk), .i_resetn(resetn), .i_en(en), .i_mode(mode), .i_step(step),
        .i_load(load), .i_load_value(lv2), .o_o(b_o), .o_tick(b_tick),
        .o_stuck(b_stuck), .o_cycle_len(b_len), .o_cycle_valid(b_valid));

    lhca_stepper #(.WIDTH(2), .RULE(2'b11), .SEED(2'b01), .PRESCALE_BITS(3), .CNT_W(16)) u_c (
        .i_clk(clk), .i_resetn(resetn), .i_en(en), .i_mode(mode), .i_step(step),
        .i_load(load), .i_load_value(lv2), .o_o(c_o), .o_tick(c_tick),
        .o_stuck(c_stuck), .o_cycle_len(c_len), .o_cycle_valid(c_valid));

    task automatic do_reset();
        en = 1'b0; mode = 1'b0; step = 1'b0; load = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // One STEP pulse; outputs are sampled 1 time unit after the edge that takes it.
    task automatic pulse_step();
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        checks++; if (a_o !== 8'h01) $display("[TB] FAIL reset_o: got %h expected 01", a_o); else passes++;
        checks++; if (a_tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b expected 0", a_tick); else passes++;
        checks++; if (a_stuck !== 1'b0) $display("[TB] FAIL reset_stuck: got %b expected 0", a_stuck); else passes++;
        checks++; if (a_len !== 16'd0) $display("[TB] FAIL reset_len: got %0d expected 0", a_len); else passes++;
        checks++; if (a_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", a_valid); else passes++;
        do_reset();
    endtask

    task automatic test_step_mode();
        logic [7:0] exp_o [3];
        exp_o = '{8'h02, 8'h07, 8'h0B};
        do_reset();
        mode = 1'b1; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse_step();
            checks++; if (a_o !== exp_o[k]) $display("[TB] FAIL step%0d_o: got %h expected %h", k, a_o, exp_o[k]); else passes++;
            checks++; if (a_tick !== 1'b1) $display("[TB] FAIL step%0d_tick: got %b expected 1", k, a_tick); else passes++;
            @(posedge clk); #1;
            checks++; if (a_tick !== 1'b0) $display("[TB] FAIL step%0d_tick_low: got %b expected 0", k, a_tick); else passes++;
            checks++; if (a_o !== exp_o[k]) $display("[TB] FAIL step%0d_hold: got %h expected %h", k, a_o, exp_o[k]); else passes++;
        end
    endtask

    task automatic test_free_run();
        logic [7:0] exp_o [3];
        exp_o = '{8'h02, 8'h07, 8'h0B};
        do_reset();
        mode = 1'b0; en = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            checks++; if (a_tick !== ((c % 8) == 0)) $display("[TB] FAIL free_tick_c%0d: got %b expected %b", c, a_tick, ((c % 8) == 0)); else passes++;
            if ((c % 8) == 0) begin
                checks++; if (a_o !== exp_o[c/8-1]) $display("[TB] FAIL free_o_c%0d: got %h expected %h", c, a_o, exp_o[c/8-1]); else passes++;
            end
        end
        en = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            checks++; if (a_tick !== 1'b0) $display("[TB] FAIL en_off_tick_c%0d: got %b expected 0", c, a_tick); else passes++;
            checks++; if (a_o !== 8'h0B) $display("[TB] FAIL en_off_hold_c%0d: got %h expected 0b", c, a_o); else passes++;
        end
        en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            checks++; if (a_tick !== (c == 8)) $display("[TB] FAIL delayed_tick_c%0d: got %b expected %b", c, a_tick, (c == 8)); else passes++;
        end
        checks++; if (a_o !== 8'h11) $display("[TB] FAIL delayed_o: got %h expected 11", a_o); else passes++;
    endtask

    task automatic test_period();
        do_reset();
        mode = 1'b1; en = 1'b1;
        pulse_step();
        checks++; if (b_o !== 2'b10) $display("[TB] FAIL period_o1: got %b expected 10", b_o); else passes++;
        checks++; if (b_valid !== 1'b0) $display("[TB] FAIL period_valid1: got %b expected 0", b_valid); else passes++;
        pulse_step();
        checks++; if (b_o !== 2'b01) $display("[TB] FAIL period_o2: got %b expected 01", b_o); else passes++;
        checks++; if (b_len !== 16'd2) $display("[TB] FAIL period_len: got %0d expected 2", b_len); else passes++;
        checks++; if (b_valid !== 1'b1) $display("[TB] FAIL period_valid2: got %b expected 1", b_valid); else passes++;
    endtask

    // Runs straight after test_period so B holds a measurement that load must keep.
    task automatic test_load();
        lv8 = 8'h5A; lv2 = 2'b10;
        load = 1'b1; step = 1'b1; mode = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; step = 1'b0; mode = 1'b0;
        checks++; if (a_o !== 8'h5A) $display("[TB] FAIL load_o: got %h expected 5a", a_o); else passes++;
        checks++; if (a_tick !== 1'b0) $display("[TB] FAIL load_tick: got %b expected 0", a_tick); else passes++;
        checks++; if (b_valid !== 1'b0) $display("[TB] FAIL load_valid: got %b expected 0", b_valid); else passes++;
        checks++; if (b_len !== 16'd2) $display("[TB] FAIL load_len_held: got %0d expected 2", b_len); else passes++;
        checks++; if (b_o !== 2'b10) $display("[TB] FAIL load_o_b: got %b expected 10", b_o); else passes++;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            checks++; if (a_tick !== (c == 8)) $display("[TB] FAIL load_presc_c%0d: got %b expected %b", c, a_tick, (c == 8)); else passes++;
        end
        checks++; if (a_o !== 8'h9B) $display("[TB] FAIL load_next_o: got %h expected 9b", a_o); else passes++;
    endtask

    task automatic test_stuck();
        do_reset();
        mode = 1'b1; en = 1'b1;
        pulse_step();
        checks++; if (c_o !== 2'b11) $display("[TB] FAIL stuck_o1: got %b expected 11", c_o); else passes++;
        pulse_step();
        checks++; if (c_o !== 2'b00) $display("[TB] FAIL stuck_o2: got %b expected 00", c_o); else passes++;
        checks++; if (c_tick !== 1'b1) $display("[TB] FAIL stuck_tick2: got %b expected 1", c_tick); else passes++;
        pulse_step();
        checks++; if (c_o !== 2'b01) $display("[TB] FAIL stuck_o3: got %b expected 01", c_o); else passes++;
        checks++; if (c_stuck !== 1'b1) $display("[TB] FAIL stuck_flag: got %b expected 1", c_stuck); else passes++;
        checks++; if (c_tick !== 1'b0) $display("[TB] FAIL stuck_tick3: got %b expected 0", c_tick); else passes++;
        @(posedge clk); #1;
        checks++; if (c_stuck !== 1'b0) $display("[TB] FAIL stuck_clear: got %b expected 0", c_stuck); else passes++;
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b0; en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        checks++; if (a_o !== 8'h02) $display("[TB] FAIL async_pre_o: got %h expected 02", a_o); else passes++;
        #3;
        resetn = 1'b0;
        #1;
        checks++; if (a_o !== 8'h01) $display("[TB] FAIL async_o: got %h expected 01", a_o); else passes++;
        checks++; if ({a_tick, a_stuck, a_valid} !== 3'b000) $display("[TB] FAIL async_flags: got %b expected 000", {a_tick, a_stuck, a_valid}); else passes++;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            checks++; if (a_tick !== (c == 8)) $display("[TB] FAIL async_resume_c%0d: got %b expected %b", c, a_tick, (c == 8)); else passes++;
        end
        checks++; if (a_o !== 8'h02) $display("[TB] FAIL async_resume_o: got %h expected 02", a_o); else passes++;
    endtask

    initial begin
        #2;
        test_reset();
        test_step_mode();
        test_free_run();
        test_period();
        test_load();
        test_stuck();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
